// File: rtl/exec_sched_pkg.sv
// Shared definitions for the execution scheduler: FSM encoding, abort/timeout
// error codes and the default queue depth.
package exec_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_ABORT,
    ST_HALT
  } state_t;

  localparam logic [7:0] ERR_ABORT   = 8'h82;
  localparam logic [7:0] ERR_TIMEOUT = 8'h83;
  localparam int QDEPTH_LOG2_DEFAULT = 4;

endpackage

// File: rtl/exec_scheduler_sync_fifo.sv
// Start-address queue: synchronous FIFO with registered level/full/empty and
// a flush that empties it in one cycle.
module sync_fifo
  import exec_sched_pkg::*;
#(
  parameter int AW = QDEPTH_LOG2_DEFAULT,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [AW:0]   next_level;

  // A push against a full queue is dropped even when a pop frees a slot.
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign next_level = level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  assign dout       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= next_level;
      full  <= next_level[AW];
      empty <= (next_level == '0);
    end
  end

endmodule

// File: rtl/exec_scheduler.sv
// Dispatches queued program start addresses to an executor, supervises each
// run with a watchdog and halts on errors or aborts until resumed.
module exec_scheduler
  import exec_sched_pkg::*;
#(
  parameter int QDEPTH_LOG2 = QDEPTH_LOG2_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          q_addr,
  input  logic                 q_wr,
  output logic                 q_full,
  output logic [QDEPTH_LOG2:0] q_level,
  input  logic                 run_en,
  input  logic                 abort_req,
  input  logic                 resume,
  input  logic [23:0]          timeout,
  output logic                 exec_start,
  output logic [15:0]          exec_start_addr,
  output logic                 exec_abort,
  input  logic                 exec_complete,
  input  logic [7:0]           exec_error,
  output logic                 busy,
  output logic                 halted,
  output logic [7:0]           last_error,
  output logic [15:0]          last_addr,
  output logic [15:0]          done_count,
  output logic                 err_int,
  output logic                 overflow
);

  state_t      state;
  logic [23:0] wdog;
  logic [15:0] head;
  logic        fifo_empty;
  logic        pop;

  assign pop = (state == ST_IDLE) && run_en && !fifo_empty && !abort_req;

  sync_fifo #(
    .AW(QDEPTH_LOG2),
    .DW(16)
  ) u_queue (
    .clk  (clk),
    .rst  (rst),
    .flush(abort_req),
    .push (q_wr),
    .din  (q_addr),
    .pop  (pop),
    .dout (head),
    .level(q_level),
    .full (q_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else begin
      if (state == ST_HALT && resume) overflow <= 1'b0;
      if (q_wr && q_full)             overflow <= 1'b1;
    end
  end

  // Host abort outranks completion, which outranks watchdog expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      wdog            <= '0;
      exec_start      <= 1'b0;
      exec_start_addr <= '0;
      exec_abort      <= 1'b0;
      busy            <= 1'b0;
      halted          <= 1'b0;
      last_error      <= '0;
      last_addr       <= '0;
      done_count      <= '0;
      err_int         <= 1'b0;
    end else begin
      exec_start <= 1'b0;
      exec_abort <= 1'b0;
      err_int    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            exec_start_addr <= head;
            last_addr       <= head;
            busy            <= 1'b1;
            state           <= ST_START;
          end
        end
        ST_START: begin
          if (abort_req) begin
            exec_abort <= 1'b1;
            last_error <= ERR_ABORT;
            err_int    <= 1'b1;
            busy       <= 1'b0;
            halted     <= 1'b1;
            state      <= ST_HALT;
          end else begin
            exec_start <= 1'b1;
            wdog       <= '0;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort_req) begin
            exec_abort <= 1'b1;
            last_error <= ERR_ABORT;
            err_int    <= 1'b1;
            busy       <= 1'b0;
            halted     <= 1'b1;
            state      <= ST_HALT;
          end else if (exec_complete) begin
            last_error <= exec_error;
            done_count <= done_count + 16'd1;
            busy       <= 1'b0;
            if (exec_error != 8'h00) begin
              err_int <= 1'b1;
              halted  <= 1'b1;
              state   <= ST_HALT;
            end else begin
              state <= ST_IDLE;
            end
          end else if (timeout != '0 && wdog == timeout) begin
            busy  <= 1'b0;
            state <= ST_ABORT;
          end else begin
            wdog <= wdog + 24'd1;
          end
        end
        ST_ABORT: begin
          exec_abort <= 1'b1;
          last_error <= ERR_TIMEOUT;
          err_int    <= 1'b1;
          halted     <= 1'b1;
          state      <= ST_HALT;
        end
        ST_HALT: begin
          if (resume) begin
            halted <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_scheduler.sv
// Randomized self-checking bench for exec_scheduler against a queue-based
// model of dispatch order, status codes, counters and watchdog timing.
module tb_exec_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] q_addr = '0;
  logic        q_wr = 1'b0;
  logic        q_full;
  logic [4:0]  q_level;
  logic        run_en = 1'b0;
  logic        abort_req = 1'b0;
  logic        resume = 1'b0;
  logic [23:0] timeout = '0;
  logic        exec_start;
  logic [15:0] exec_start_addr;
  logic        exec_abort;
  logic        exec_complete = 1'b0;
  logic [7:0]  exec_error = '0;
  logic        busy;
  logic        halted;
  logic [7:0]  last_error;
  logic [15:0] last_addr;
  logic [15:0] done_count;
  logic        err_int;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  logic [15:0] model_q[$];
  int          exp_done = 0;
  logic [7:0]  exp_err = '0;
  logic        exp_ovf = 1'b0;

  exec_scheduler #(.QDEPTH_LOG2(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .q_addr         (q_addr),
    .q_wr           (q_wr),
    .q_full         (q_full),
    .q_level        (q_level),
    .run_en         (run_en),
    .abort_req      (abort_req),
    .resume         (resume),
    .timeout        (timeout),
    .exec_start     (exec_start),
    .exec_start_addr(exec_start_addr),
    .exec_abort     (exec_abort),
    .exec_complete  (exec_complete),
    .exec_error     (exec_error),
    .busy           (busy),
    .halted         (halted),
    .last_error     (last_error),
    .last_addr      (last_addr),
    .done_count     (done_count),
    .err_int        (err_int),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=stuck expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Enqueue one address; the model keeps at most 16 and records drops.
  task automatic applyStimulus(input logic [15:0] addr);
    q_addr = addr;
    q_wr   = 1'b1;
    @(negedge clk);
    q_wr   = 1'b0;
    if (model_q.size() < 16) model_q.push_back(addr);
    else exp_ovf = 1'b1;
  endtask

  task automatic takeDispatch(input string tag, input int exp_lat);
    int lat;
    bit seen;
    logic [15:0] exp_a;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 300) begin
      @(negedge clk);
      lat++;
      seen = exec_start;
    end
    checkOutput({tag, "_start_seen"}, 32'(seen), 1);
    if (exp_lat > 0) checkOutput({tag, "_latency"}, lat, exp_lat);
    if (model_q.size() == 0) begin
      checkOutput({tag, "_dispatch_from_empty"}, 1, 0);
    end else begin
      exp_a = model_q.pop_front();
      checkOutput({tag, "_addr"}, exec_start_addr, exp_a);
      checkOutput({tag, "_last_addr"}, last_addr, exp_a);
      checkOutput({tag, "_busy"}, busy, 1);
    end
  endtask

  task automatic doResume(input string tag);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    exp_ovf = 1'b0;
    checkOutput({tag, "_resume_halted"}, halted, 0);
    checkOutput({tag, "_resume_busy"}, busy, 0);
    checkOutput({tag, "_resume_ovf"}, overflow, exp_ovf);
  endtask

  task automatic finishProgram(input string tag, input logic [7:0] err, input int delay);
    @(negedge clk);
    checkOutput({tag, "_start_one_cycle"}, exec_start, 0);
    repeat (delay - 1) @(negedge clk);
    exec_error    = err;
    exec_complete = 1'b1;
    @(negedge clk);
    exec_complete = 1'b0;
    exec_error    = '0;
    exp_done++;
    exp_err = err;
    checkOutput({tag, "_done_count"}, done_count, exp_done);
    checkOutput({tag, "_last_error"}, last_error, exp_err);
    checkOutput({tag, "_err_int"}, err_int, 32'(err != 0));
    checkOutput({tag, "_halted"}, halted, 32'(err != 0));
    checkOutput({tag, "_busy_after"}, busy, 0);
    checkOutput({tag, "_no_abort"}, exec_abort, 0);
    @(negedge clk);
    checkOutput({tag, "_err_int_pulse"}, err_int, 0);
    if (err != 0) doResume(tag);
  endtask

  task automatic timeoutRun(input int t);
    int cnt;
    timeout = 24'(t);
    applyStimulus(16'($urandom));
    takeDispatch("wdog", 2);
    cnt = 0;
    while (!exec_abort && cnt < t + 50) begin
      @(negedge clk);
      cnt++;
    end
    exp_err = 8'h83;
    checkOutput("wdog_cycles", cnt, t + 2);
    checkOutput("wdog_last_error", last_error, exp_err);
    checkOutput("wdog_halted", halted, 1);
    checkOutput("wdog_err_int", err_int, 1);
    checkOutput("wdog_done_count", done_count, exp_done);
    @(negedge clk);
    checkOutput("wdog_abort_pulse", exec_abort, 0);
    doResume("wdog");
    timeout = '0;
  endtask

  initial begin
    int t;
    int seen_cnt;
    logic [7:0] err;

    repeat (3) @(negedge clk);
    checkOutput("rst_q_level", q_level, 0);
    checkOutput("rst_q_full", q_full, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_done_count", done_count, 0);
    checkOutput("rst_last_error", last_error, 0);
    checkOutput("rst_start_addr", exec_start_addr, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_exec_start", exec_start, 0);
    rst = 1'b0;
    @(negedge clk);

    run_en = 1'b1;
    applyStimulus(16'h0010);
    takeDispatch("basic", 2);
    finishProgram("basic", 8'h00, 3);

    applyStimulus(16'($urandom));
    takeDispatch("err05", 2);
    finishProgram("err05", 8'h05, 2);

    for (int i = 0; i < 6; i++) begin
      err = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      applyStimulus(16'($urandom));
      takeDispatch("rand", 2);
      finishProgram("rand", err, $urandom_range(1, 12));
    end

    timeoutRun($urandom_range(5, 40));
    timeoutRun(100);

    // Completion lands on the exact watchdog expiry edge.
    t = $urandom_range(3, 20);
    timeout = 24'(t);
    applyStimulus(16'($urandom));
    takeDispatch("race", 2);
    repeat (t) @(negedge clk);
    exec_complete = 1'b1;
    @(negedge clk);
    exec_complete = 1'b0;
    exp_done++;
    exp_err = 8'h00;
    checkOutput("race_done_count", done_count, exp_done);
    checkOutput("race_last_error", last_error, exp_err);
    checkOutput("race_halted", halted, 0);
    seen_cnt = 0;
    repeat (5) begin
      if (exec_abort) seen_cnt++;
      @(negedge clk);
    end
    checkOutput("race_no_abort", seen_cnt, 0);
    timeout = '0;

    applyStimulus(16'($urandom));
    takeDispatch("abort", 2);
    repeat (3) applyStimulus(16'($urandom));
    checkOutput("abort_pre_level", q_level, model_q.size());
    abort_req = 1'b1;
    @(negedge clk);
    abort_req = 1'b0;
    model_q.delete();
    exp_err = 8'h82;
    checkOutput("abort_exec_abort", exec_abort, 1);
    checkOutput("abort_q_level", q_level, model_q.size());
    checkOutput("abort_last_error", last_error, exp_err);
    checkOutput("abort_halted", halted, 1);
    checkOutput("abort_err_int", err_int, 1);
    @(negedge clk);
    checkOutput("abort_pulse", exec_abort, 0);
    doResume("abort");
    seen_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (exec_start) seen_cnt++;
    end
    checkOutput("abort_no_dispatch", seen_cnt, 0);

    run_en = 1'b0;
    repeat (3) applyStimulus(16'($urandom));
    checkOutput("pp_pre_level", q_level, 3);
    q_addr = 16'($urandom);
    q_wr   = 1'b1;
    run_en = 1'b1;
    @(negedge clk);
    q_wr = 1'b0;
    model_q.push_back(q_addr);
    checkOutput("pp_level_unchanged", q_level, 3);
    for (int i = 0; i < 4; i++) begin
      takeDispatch("pp", 0);
      finishProgram("pp", 8'h00, $urandom_range(1, 4));
    end

    run_en = 1'b0;
    repeat (17) applyStimulus(16'($urandom));
    checkOutput("ovf_q_level", q_level, model_q.size());
    checkOutput("ovf_q_full", q_full, 1);
    checkOutput("ovf_flag", overflow, exp_ovf);
    run_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      takeDispatch("drain", 0);
      finishProgram("drain", 8'h00, 1);
    end
    seen_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (exec_start) seen_cnt++;
    end
    checkOutput("ovf_no_17th", seen_cnt, 0);
    checkOutput("ovf_drained_level", q_level, 0);
    checkOutput("ovf_sticky", overflow, exp_ovf);
    applyStimulus(16'($urandom));
    takeDispatch("ovf_clear", 2);
    finishProgram("ovf_clear", 8'h21, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
